// File: rtl/phy_conf_seq_if.sv
// MIIM request/response bundle between the configuration sequencer and the MIIM master.
interface phy_conf_seq_if;
  logic        busy;
  logic [15:0] miim_rddata;
  logic        miim_rddata_valid;
  logic [4:0]  miim_phyad;
  logic [4:0]  miim_regad;
  logic [15:0] miim_wrdata;
  logic        miim_wren;
  logic        miim_rden;

  // Sequencer side: issues requests, observes completion.
  modport master (
    input  busy, miim_rddata, miim_rddata_valid,
    output miim_phyad, miim_regad, miim_wrdata, miim_wren, miim_rden
  );

  // MIIM master side: accepts requests, reports busy and read data.
  modport slave (
    output busy, miim_rddata, miim_rddata_valid,
    input  miim_phyad, miim_regad, miim_wrdata, miim_wren, miim_rden
  );
endinterface

// File: rtl/phy_conf_seq.sv
// Script-driven MIIM configuration sequencer: runs NUM_OPS write / read-capture /
// read-verify / poll entries after reset or start, reporting done or the failing op.
module phy_conf_seq #(
  parameter int unsigned          NUM_OPS      = 4,
  parameter logic [4:0]           PHYAD        = 5'b00000,
  parameter logic [NUM_OPS*40-1:0] SCRIPT      = {
    {2'b11, 1'b0, 5'd1, 16'h0004, 16'h0004},
    {2'b10, 1'b0, 5'd0, 16'h0044, 16'hFFFF},
    {2'b01, 1'b0, 5'd2, 16'h0000, 16'h0000},
    {2'b00, 1'b0, 5'd0, 16'h0044, 16'h0000}
  },
  parameter int unsigned          START_DELAY  = 255,
  parameter int unsigned          MAX_RETRY    = 3,
  parameter int unsigned          MAX_POLL     = 16,
  parameter int unsigned          POLL_GAP     = 1000,
  parameter int unsigned          BUSY_TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  phy_conf_seq_if.master       miim,
  output logic                 done,
  output logic                 error,
  output logic [5:0]           err_idx,
  output logic [1:0]           err_code,
  output logic [15:0]          cap_data,
  output logic [5:0]           cap_idx,
  output logic                 cap_valid
);

  localparam int unsigned ENT_W = 40;
  localparam int unsigned IDX_W = 6;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned ATT_W = 16;

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RC   = 2'b01;
  localparam logic [1:0] OP_RV   = 2'b10;
  localparam logic [1:0] OP_POLL = 2'b11;

  localparam logic [1:0] EC_VERIFY  = 2'b01;
  localparam logic [1:0] EC_POLL    = 2'b10;
  localparam logic [1:0] EC_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_DELAY, S_FETCH, S_ISSUE, S_WAIT, S_CHECK, S_GAP, S_DONE, S_ERR
  } state_e;

  // Latched script entry; the reserved bit is never stored.
  typedef struct packed {
    logic [1:0]  op;
    logic [4:0]  regad;
    logic [15:0] data;
    logic [15:0] mask;
  } entry_t;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   op_idx_q, op_idx_d;
  logic [ATT_W-1:0]   att_q, att_d;
  entry_t             entry_q, entry_d;
  logic [15:0]        rd_data_q, rd_data_d;
  logic               seen_busy_q, seen_busy_d;

  logic [4:0]         phyad_q, phyad_d;
  logic [4:0]         regad_q, regad_d;
  logic [15:0]        wrdata_q, wrdata_d;
  logic               wren_q, wren_d;
  logic               rden_q, rden_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [IDX_W-1:0]   err_idx_q, err_idx_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [15:0]        cap_data_q, cap_data_d;
  logic [IDX_W-1:0]   cap_idx_q, cap_idx_d;
  logic               cap_valid_q, cap_valid_d;

  logic [31:0]        base_c;
  logic               rd_match_c;
  logic               op_complete_c;
  logic               advance_c;

  assign base_c     = ENT_W * 32'(op_idx_q);
  assign rd_match_c = ((rd_data_q & entry_q.mask) == (entry_q.data & entry_q.mask));

  // Next-state and registered-output logic for the script engine.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_idx_d    = op_idx_q;
    att_d       = att_q;
    entry_d     = entry_q;
    rd_data_d   = rd_data_q;
    seen_busy_d = seen_busy_q;
    phyad_d     = phyad_q;
    regad_d     = regad_q;
    wrdata_d    = wrdata_q;
    wren_d      = 1'b0;
    rden_d      = 1'b0;
    done_d      = done_q;
    error_d     = error_q;
    err_idx_d   = err_idx_q;
    err_code_d  = err_code_q;
    cap_data_d  = cap_data_q;
    cap_idx_d   = cap_idx_q;
    cap_valid_d = 1'b0;
    op_complete_c = 1'b0;
    advance_c     = 1'b0;

    case (state_q)
      S_DELAY: begin
        if (cnt_q == CNT_W'(START_DELAY)) begin
          cnt_d   = '0;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_FETCH: begin
        entry_d.op    = SCRIPT[base_c + 32'd38 +: 2];
        entry_d.regad = SCRIPT[base_c + 32'd32 +: 5];
        entry_d.data  = SCRIPT[base_c + 32'd16 +: 16];
        entry_d.mask  = SCRIPT[base_c +: 16];
        att_d         = '0;
        state_d       = S_ISSUE;
      end

      S_ISSUE: begin
        phyad_d     = PHYAD;
        regad_d     = entry_q.regad;
        wrdata_d    = entry_q.data;
        wren_d      = (entry_q.op == OP_WR);
        rden_d      = (entry_q.op != OP_WR);
        seen_busy_d = 1'b0;
        cnt_d       = '0;
        state_d     = S_WAIT;
      end

      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (miim.busy) seen_busy_d = 1'b1;
        if (entry_q.op == OP_WR) begin
          op_complete_c = seen_busy_q && !miim.busy;
        end else if (miim.miim_rddata_valid) begin
          op_complete_c = 1'b1;
          rd_data_d     = miim.miim_rddata;
        end
        if (op_complete_c) begin
          state_d = S_CHECK;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT)) begin
          error_d    = 1'b1;
          err_idx_d  = op_idx_q;
          err_code_d = EC_TIMEOUT;
          state_d    = S_ERR;
        end
      end

      S_CHECK: begin
        case (entry_q.op)
          OP_WR: advance_c = 1'b1;
          OP_RC: begin
            cap_data_d  = rd_data_q;
            cap_idx_d   = op_idx_q;
            cap_valid_d = 1'b1;
            advance_c   = 1'b1;
          end
          OP_RV: begin
            if (rd_match_c) begin
              advance_c = 1'b1;
            end else if (att_q < ATT_W'(MAX_RETRY)) begin
              att_d   = att_q + ATT_W'(1);
              state_d = S_ISSUE;
            end else begin
              error_d    = 1'b1;
              err_idx_d  = op_idx_q;
              err_code_d = EC_VERIFY;
              state_d    = S_ERR;
            end
          end
          default: begin
            if (rd_match_c) begin
              advance_c = 1'b1;
            end else if ((att_q + ATT_W'(1)) < ATT_W'(MAX_POLL)) begin
              att_d   = att_q + ATT_W'(1);
              cnt_d   = '0;
              state_d = S_GAP;
            end else begin
              error_d    = 1'b1;
              err_idx_d  = op_idx_q;
              err_code_d = EC_POLL;
              state_d    = S_ERR;
            end
          end
        endcase
        if (advance_c) begin
          if (op_idx_q == IDX_W'(NUM_OPS - 1)) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            op_idx_d = op_idx_q + IDX_W'(1);
            state_d  = S_FETCH;
          end
        end
      end

      S_GAP: begin
        if ((cnt_q + CNT_W'(1)) >= CNT_W'(POLL_GAP)) begin
          state_d = S_ISSUE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE, S_ERR: begin
        if (start) begin
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_code_d = 2'b00;
          op_idx_d   = '0;
          cnt_d      = '0;
          state_d    = S_DELAY;
        end
      end

      default: state_d = S_DELAY;
    endcase
  end

  // State and output registers; reset restarts from the delay phase.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_DELAY;
      cnt_q       <= '0;
      op_idx_q    <= '0;
      att_q       <= '0;
      entry_q     <= '0;
      rd_data_q   <= '0;
      seen_busy_q <= 1'b0;
      phyad_q     <= '0;
      regad_q     <= '0;
      wrdata_q    <= '0;
      wren_q      <= 1'b0;
      rden_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_idx_q   <= '0;
      err_code_q  <= '0;
      cap_data_q  <= '0;
      cap_idx_q   <= '0;
      cap_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_idx_q    <= op_idx_d;
      att_q       <= att_d;
      entry_q     <= entry_d;
      rd_data_q   <= rd_data_d;
      seen_busy_q <= seen_busy_d;
      phyad_q     <= phyad_d;
      regad_q     <= regad_d;
      wrdata_q    <= wrdata_d;
      wren_q      <= wren_d;
      rden_q      <= rden_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_idx_q   <= err_idx_d;
      err_code_q  <= err_code_d;
      cap_data_q  <= cap_data_d;
      cap_idx_q   <= cap_idx_d;
      cap_valid_q <= cap_valid_d;
    end
  end

  assign miim.miim_phyad  = phyad_q;
  assign miim.miim_regad  = regad_q;
  assign miim.miim_wrdata = wrdata_q;
  assign miim.miim_wren   = wren_q;
  assign miim.miim_rden   = rden_q;
  assign done             = done_q;
  assign error            = error_q;
  assign err_idx          = err_idx_q;
  assign err_code         = err_code_q;
  assign cap_data         = cap_data_q;
  assign cap_idx          = cap_idx_q;
  assign cap_valid        = cap_valid_q;

endmodule

// File: tb/tb_phy_conf_seq.sv
// Directed bench for phy_conf_seq with a 20-cycle MIIM master model.
module tb_phy_conf_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        done, error, cap_valid;
  logic [5:0]  err_idx, cap_idx;
  logic [1:0]  err_code;
  logic [15:0] cap_data;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  phy_conf_seq_if miim_if ();

  phy_conf_seq dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .miim      (miim_if.master),
    .done      (done),
    .error     (error),
    .err_idx   (err_idx),
    .err_code  (err_code),
    .cap_data  (cap_data),
    .cap_idx   (cap_idx),
    .cap_valid (cap_valid)
  );

  always #5 clk = ~clk;

  // Model behaviour knobs, written only by the test tasks.
  bit verify_bad = 1'b0;
  bit poll_never = 1'b0;
  bit hold_mode  = 1'b0;

  // MIIM master model: busy for 20 cycles per request, read data on the last one.
  int unsigned m_cnt;
  bit          m_rd;
  logic [4:0]  m_reg;
  int unsigned poll_reads;
  bit          stuck;

  function automatic logic [15:0] rd_value(input logic [4:0] r, input int unsigned pr);
    if (r == 5'd2) return 16'h0283;
    if (r == 5'd0) return verify_bad ? 16'h0040 : 16'h0044;
    if (r == 5'd1) return (!poll_never && pr >= 3) ? 16'h0004 : 16'h0000;
    return 16'h0000;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      miim_if.busy              <= 1'b0;
      miim_if.miim_rddata       <= 16'h0;
      miim_if.miim_rddata_valid <= 1'b0;
      m_cnt <= 0; m_rd <= 1'b0; m_reg <= 5'd0; poll_reads <= 0; stuck <= 1'b0;
    end else begin
      miim_if.miim_rddata_valid <= 1'b0;
      if (stuck) begin
        if (!hold_mode) begin
          miim_if.busy <= 1'b0;
          stuck <= 1'b0;
        end
      end else if (miim_if.miim_wren || miim_if.miim_rden) begin
        miim_if.busy <= 1'b1;
        m_rd  <= miim_if.miim_rden;
        m_reg <= miim_if.miim_regad;
        if (miim_if.miim_rden && miim_if.miim_regad == 5'd1) poll_reads <= poll_reads + 1;
        if (miim_if.miim_wren && hold_mode) begin
          stuck <= 1'b1;
          m_cnt <= 0;
        end else begin
          m_cnt <= 20;
        end
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          miim_if.busy <= 1'b0;
          if (m_rd) begin
            miim_if.miim_rddata_valid <= 1'b1;
            miim_if.miim_rddata       <= rd_value(m_reg, poll_reads);
          end
        end
      end
    end
  end

  // Cycle counter: value k during the cycle after the k-th rising edge since reset release.
  int unsigned cyc;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Request/capture monitor sampled on the falling edge.
  int unsigned wr_cnt [32];
  int unsigned rd_cnt [32];
  int unsigned first_wr_cyc;
  logic [4:0]  first_wr_reg;
  logic [15:0] first_wr_data;
  int unsigned cap_cnt;
  logic [15:0] cap_last_data;
  logic [5:0]  cap_last_idx;
  int unsigned last_poll_cyc;
  int unsigned min_poll_gap;
  int unsigned err_cyc;

  always @(negedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) begin
        wr_cnt[i] <= 0;
        rd_cnt[i] <= 0;
      end
      first_wr_cyc <= 0; first_wr_reg <= 5'd0; first_wr_data <= 16'h0;
      cap_cnt <= 0; cap_last_data <= 16'h0; cap_last_idx <= 6'd0;
      last_poll_cyc <= 0; min_poll_gap <= 32'hFFFF_FFFF; err_cyc <= 0;
    end else begin
      if (miim_if.miim_wren) begin
        wr_cnt[miim_if.miim_regad] <= wr_cnt[miim_if.miim_regad] + 1;
        if (first_wr_cyc == 0) begin
          first_wr_cyc  <= cyc;
          first_wr_reg  <= miim_if.miim_regad;
          first_wr_data <= miim_if.miim_wrdata;
        end
      end
      if (miim_if.miim_rden) begin
        rd_cnt[miim_if.miim_regad] <= rd_cnt[miim_if.miim_regad] + 1;
        if (miim_if.miim_regad == 5'd1) begin
          if (last_poll_cyc != 0 && (cyc - last_poll_cyc) < min_poll_gap)
            min_poll_gap <= cyc - last_poll_cyc;
          last_poll_cyc <= cyc;
        end
      end
      if (cap_valid) begin
        cap_cnt       <= cap_cnt + 1;
        cap_last_data <= cap_data;
        cap_last_idx  <= cap_idx;
      end
      if (error && err_cyc == 0) err_cyc <= cyc;
    end
  end

  task automatic reset_and_release();
    @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;
  endtask

  task automatic wait_end(input int unsigned max_cyc, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < int'(max_cyc); i++) begin
      @(negedge clk);
      if (done || error) begin
        hit = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if ({done, error, cap_valid} !== 3'b000) $display("FAIL reset_status: got %b want 000", {done, error, cap_valid}); else n_pass++;
    n_total++; if ({miim_if.miim_wren, miim_if.miim_rden} !== 2'b00) $display("FAIL reset_req: got %b want 00", {miim_if.miim_wren, miim_if.miim_rden}); else n_pass++;
    n_total++; if ({err_idx, err_code} !== 8'h00) $display("FAIL reset_err: got %h want 00", {err_idx, err_code}); else n_pass++;
    n_total++; if ({cap_data, cap_idx} !== 22'h0) $display("FAIL reset_cap: got %h want 0", {cap_data, cap_idx}); else n_pass++;
    n_total++; if ({miim_if.miim_phyad, miim_if.miim_regad, miim_if.miim_wrdata} !== 26'h0) $display("FAIL reset_bus: got %h want 0", {miim_if.miim_phyad, miim_if.miim_regad, miim_if.miim_wrdata}); else n_pass++;
  endtask

  task automatic test_default();
    bit hit;
    reset_and_release();
    wait_end(20000, hit);
    n_total++; if (!hit) $display("FAIL default_end: script did not finish in 20000 cycles"); else n_pass++;
    n_total++; if (first_wr_cyc !== 258) $display("FAIL default_first_wren_cyc: got %0d want 258", first_wr_cyc); else n_pass++;
    n_total++; if (first_wr_reg !== 5'd0 || first_wr_data !== 16'h0044) $display("FAIL default_first_wren: got reg %0d data %h want reg 0 data 0044", first_wr_reg, first_wr_data); else n_pass++;
    n_total++; if (cap_cnt !== 1 || cap_last_idx !== 6'd1 || cap_last_data !== 16'h0283) $display("FAIL default_capture: got cnt %0d idx %0d data %h want 1 1 0283", cap_cnt, cap_last_idx, cap_last_data); else n_pass++;
    n_total++; if (rd_cnt[0] !== 1) $display("FAIL default_verify_reads: got %0d want 1", rd_cnt[0]); else n_pass++;
    n_total++; if (rd_cnt[1] !== 3) $display("FAIL default_poll_reads: got %0d want 3", rd_cnt[1]); else n_pass++;
    n_total++; if (min_poll_gap < 1000) $display("FAIL default_poll_gap: got %0d want >=1000", min_poll_gap); else n_pass++;
    n_total++; if (done !== 1'b1 || error !== 1'b0) $display("FAIL default_status: got done %b error %b want 1 0", done, error); else n_pass++;
  endtask

  task automatic test_verify_fail();
    bit hit;
    verify_bad = 1'b1;
    reset_and_release();
    wait_end(20000, hit);
    n_total++; if (!hit) $display("FAIL verify_end: script did not finish in 20000 cycles"); else n_pass++;
    n_total++; if (rd_cnt[0] !== 4) $display("FAIL verify_reads: got %0d want 4", rd_cnt[0]); else n_pass++;
    n_total++; if ({done, error} !== 2'b01) $display("FAIL verify_status: got done %b error %b want 0 1", done, error); else n_pass++;
    n_total++; if (err_idx !== 6'd2 || err_code !== 2'b01) $display("FAIL verify_err: got idx %0d code %b want 2 01", err_idx, err_code); else n_pass++;
    n_total++; if (rd_cnt[1] !== 0) $display("FAIL verify_no_poll: got %0d want 0", rd_cnt[1]); else n_pass++;
    verify_bad = 1'b0;
  endtask

  task automatic test_poll_exhaust();
    bit hit;
    poll_never = 1'b1;
    reset_and_release();
    wait_end(40000, hit);
    n_total++; if (!hit) $display("FAIL poll_end: script did not finish in 40000 cycles"); else n_pass++;
    n_total++; if (rd_cnt[1] !== 16) $display("FAIL poll_reads: got %0d want 16", rd_cnt[1]); else n_pass++;
    n_total++; if (err_idx !== 6'd3 || err_code !== 2'b10 || error !== 1'b1 || done !== 1'b0) $display("FAIL poll_err: got idx %0d code %b error %b done %b want 3 10 1 0", err_idx, err_code, error, done); else n_pass++;
    n_total++; if (min_poll_gap < 1000) $display("FAIL poll_gap: got %0d want >=1000", min_poll_gap); else n_pass++;
    poll_never = 1'b0;
  endtask

  task automatic test_busy_timeout();
    bit hit;
    hold_mode = 1'b1;
    reset_and_release();
    wait_end(8000, hit);
    n_total++; if (!hit) $display("FAIL timeout_end: no error within 8000 cycles"); else n_pass++;
    n_total++; if (err_idx !== 6'd0 || err_code !== 2'b11 || error !== 1'b1 || done !== 1'b0) $display("FAIL timeout_err: got idx %0d code %b error %b done %b want 0 11 1 0", err_idx, err_code, error, done); else n_pass++;
    n_total++; if (err_cyc < 258 + 4096 || err_cyc > 258 + 4100) $display("FAIL timeout_cyc: got %0d want 4354..4358", err_cyc); else n_pass++;
    hold_mode = 1'b0;
    repeat (3) @(negedge clk);
    pulse_start();
    n_total++; if ({done, error, err_code} !== 4'b0000) $display("FAIL restart_clear: got %b want 0000", {done, error, err_code}); else n_pass++;
    wait_end(20000, hit);
    n_total++; if (!hit) $display("FAIL restart_end: script did not finish in 20000 cycles"); else n_pass++;
    n_total++; if (done !== 1'b1 || error !== 1'b0) $display("FAIL restart_status: got done %b error %b want 1 0", done, error); else n_pass++;
    n_total++; if (wr_cnt[0] !== 2 || cap_cnt !== 1 || rd_cnt[1] !== 3) $display("FAIL restart_counts: got wr %0d cap %0d poll %0d want 2 1 3", wr_cnt[0], cap_cnt, rd_cnt[1]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit seen;
    reset_and_release();
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rd_cnt[2] != 0) begin
        seen = 1'b1;
        break;
      end
    end
    n_total++; if (!seen) $display("FAIL midrst_reach_op1: op1 read not seen in 1000 cycles"); else n_pass++;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    n_total++; if ({done, error, cap_valid, miim_if.miim_wren, miim_if.miim_rden} !== 5'b0) $display("FAIL midrst_ctrl: got %b want 00000", {done, error, cap_valid, miim_if.miim_wren, miim_if.miim_rden}); else n_pass++;
    n_total++; if ({miim_if.miim_regad, miim_if.miim_wrdata, err_code} !== 23'h0) $display("FAIL midrst_bus: got %h want 0", {miim_if.miim_regad, miim_if.miim_wrdata, err_code}); else n_pass++;
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (wr_cnt[0] != 0) begin
        seen = 1'b1;
        break;
      end
    end
    n_total++; if (!seen || first_wr_cyc !== 258 || first_wr_reg !== 5'd0) $display("FAIL midrst_rerun: got seen %b cyc %0d reg %0d want 1 258 0", seen, first_wr_cyc, first_wr_reg); else n_pass++;
  endtask

  task automatic test_start_ignored();
    bit hit;
    bit seen;
    reset_and_release();
    repeat (100) @(negedge clk);
    pulse_start();
    repeat (170) @(negedge clk);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rd_cnt[1] != 0) begin
        seen = 1'b1;
        break;
      end
    end
    n_total++; if (!seen) $display("FAIL start_reach_poll: poll read not seen in 3000 cycles"); else n_pass++;
    repeat (30) @(negedge clk);
    pulse_start();
    wait_end(20000, hit);
    n_total++; if (!hit || done !== 1'b1 || error !== 1'b0) $display("FAIL start_status: got end %b done %b error %b want 1 1 0", hit, done, error); else n_pass++;
    n_total++; if (first_wr_cyc !== 258) $display("FAIL start_first_wren: got %0d want 258", first_wr_cyc); else n_pass++;
    n_total++; if (wr_cnt[0] !== 1 || rd_cnt[2] !== 1 || rd_cnt[0] !== 1 || rd_cnt[1] !== 3) $display("FAIL start_req_counts: got wr0 %0d rd2 %0d rd0 %0d rd1 %0d want 1 1 1 3", wr_cnt[0], rd_cnt[2], rd_cnt[0], rd_cnt[1]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_default();
    test_verify_fail();
    test_poll_exhaust();
    test_busy_timeout();
    test_reset_mid();
    test_start_ignored();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
